// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises active-low keys, debounces each channel
// and produces a clean level plus registered press, release and auto-repeat strobes.
module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_REPEAT
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HD_W     = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(HOLD_CYCLES - 1);
    localparam logic [HD_W-1:0] RPT_LAST  = HD_W'(REPEAT_CYCLES - 1);
    localparam logic            RPT_ON    = (REPEAT_EN != 0);

    // Bit 1 of the state is the debounced level, so KEY_LEVEL comes straight from a flop.
    localparam logic [1:0] ST_RELEASED    = 2'b00;
    localparam logic [1:0] ST_PRESS_CHK   = 2'b01;
    localparam logic [1:0] ST_PRESSED     = 2'b10;
    localparam logic [1:0] ST_RELEASE_CHK = 2'b11;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [SYNC_STAGES-1:0] r_sync;
        logic [1:0]             r_state;
        logic [DB_W-1:0]        r_dbCnt;
        logic [HD_W-1:0]        r_holdCnt;
        logic                   r_rptPhase;
        logic                   r_press;
        logic                   r_release;
        logic                   r_repeat;
        logic                   w_s;
        logic                   w_dbDone;
        logic                   w_releaseEdge;
        logic                   w_holdDone;

        // Synchroniser keeps raw polarity (1 = released); inversion happens at its output.
        assign w_s           = ~r_sync[SYNC_STAGES-1];
        assign w_dbDone      = (r_dbCnt == DB_LAST);
        assign w_releaseEdge = (r_state == ST_RELEASE_CHK) && !w_s && w_dbDone;
        assign w_holdDone    = r_rptPhase ? (r_holdCnt == RPT_LAST) : (r_holdCnt == HOLD_LAST);

        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                r_sync     <= '1;
                r_state    <= ST_RELEASED;
                r_dbCnt    <= '0;
                r_holdCnt  <= '0;
                r_rptPhase <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], KEY[i]};
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;

                case (r_state)
                    ST_RELEASED: begin
                        if (w_s) begin
                            r_state <= ST_PRESS_CHK;
                            r_dbCnt <= r_dbCnt + 1'b1;
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASED;
                            r_dbCnt <= '0;
                        end else if (w_dbDone) begin
                            r_state <= ST_PRESSED;
                            r_dbCnt <= '0;
                            r_press <= 1'b1;
                        end else begin
                            r_dbCnt <= r_dbCnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASE_CHK;
                            r_dbCnt <= r_dbCnt + 1'b1;
                        end
                    end
                    default: begin
                        if (w_s) begin
                            r_state <= ST_PRESSED;
                            r_dbCnt <= '0;
                        end else if (w_dbDone) begin
                            r_state   <= ST_RELEASED;
                            r_dbCnt   <= '0;
                            r_release <= 1'b1;
                        end else begin
                            r_dbCnt <= r_dbCnt + 1'b1;
                        end
                    end
                endcase

                // The release edge wins over a coincident repeat so the two strobes never overlap.
                if (!r_state[1] || w_releaseEdge) begin
                    r_holdCnt  <= '0;
                    r_rptPhase <= 1'b0;
                end else if (w_holdDone) begin
                    r_holdCnt  <= '0;
                    r_rptPhase <= 1'b1;
                    r_repeat   <= RPT_ON;
                end else begin
                    r_holdCnt <= r_holdCnt + 1'b1;
                end
            end
        end

        assign KEY_LEVEL[i]   = r_state[1];
        assign KEY_PRESS[i]   = r_press;
        assign KEY_RELEASE[i] = r_release;
        assign KEY_REPEAT[i]  = r_repeat;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/hold/repeat parameters:
// a vector table for the basic sequences plus hand-written repeat and reset sequences.
module tb_key_debounce;

   logic       CLOCK_50;
   logic       RESET_N;
   logic [3:0] KEY;
   logic [3:0] KEY_LEVEL;
   logic [3:0] KEY_PRESS;
   logic [3:0] KEY_RELEASE;
   logic [3:0] KEY_REPEAT;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      string      name;
      logic       rstN;
      logic [3:0] key;
      int         ticks;
      logic [3:0] expLevel;
      logic [3:0] expPress;
      logic [3:0] expRelease;
      logic [3:0] expRepeat;
   } vec_t;

   vec_t vecs[$];

   key_debounce #(
      .NUM_KEYS(4),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(8),
      .REPEAT_EN(1),
      .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET_N(RESET_N),
      .KEY(KEY),
      .KEY_LEVEL(KEY_LEVEL),
      .KEY_PRESS(KEY_PRESS),
      .KEY_RELEASE(KEY_RELEASE),
      .KEY_REPEAT(KEY_REPEAT)
   );

   // 50 MHz clock
   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic applyStimulus(input logic rstN, input logic [3:0] key);
      RESET_N = rstN;
      KEY     = key;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                              input logic [3:0] rel, input logic [3:0] rpt);
      checkCount++;
      if ({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT} !== {lvl, prs, rel, rpt}) begin
         errorCount++;
         $display("[TB] FAIL %s: level/press/release/repeat got %h/%h/%h/%h expected %h/%h/%h/%h",
                  name, KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, lvl, prs, rel, rpt);
      end
   endtask

   initial begin
      applyStimulus(1'b0, 4'hF);

      // name, rstN, key, ticks, level, press, release, repeat
      vecs.push_back('{"reset",        1'b0, 4'hF,   3, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"idle100",      1'b1, 4'hF, 100, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k0_prepress",  1'b1, 4'hE,   9, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k0_press",     1'b1, 4'hE,   1, 4'h1, 4'h1, 4'h0, 4'h0});
      vecs.push_back('{"k0_pressoff",  1'b1, 4'hE,   1, 4'h1, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k0_prerel",    1'b1, 4'hF,   9, 4'h1, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k0_release",   1'b1, 4'hF,   1, 4'h0, 4'h0, 4'h1, 4'h0});
      vecs.push_back('{"k0_reloff",    1'b1, 4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k1_bounce_a",  1'b1, 4'hD,   5, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k1_bounce_b",  1'b1, 4'hF,   2, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k1_bounce_c",  1'b1, 4'hD,   5, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k1_bounce_d",  1'b1, 4'hF,  20, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k03_prepress", 1'b1, 4'h6,   9, 4'h0, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k03_press",    1'b1, 4'h6,   1, 4'h9, 4'h9, 4'h0, 4'h0});
      vecs.push_back('{"k03_pressoff", 1'b1, 4'h6,   1, 4'h9, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k03_prerel",   1'b1, 4'hF,   9, 4'h9, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{"k03_release",  1'b1, 4'hF,   1, 4'h0, 4'h0, 4'h9, 4'h0});
      vecs.push_back('{"k03_reloff",   1'b1, 4'hF,   1, 4'h0, 4'h0, 4'h0, 4'h0});

      for (int v = 0; v < vecs.size(); v++) begin
         applyStimulus(vecs[v].rstN, vecs[v].key);
         for (int t = 0; t < vecs[v].ticks; t++) tick();
         checkOutput(vecs[v].name, vecs[v].expLevel, vecs[v].expPress,
                     vecs[v].expRelease, vecs[v].expRepeat);
      end

      // Key 2 held for 50 cycles: press at tick 10, repeats at 30,35,...,55; the
      // repeat due at 60 coincides with the release and must be suppressed.
      applyStimulus(1'b1, 4'hB);
      for (int t = 1; t <= 80; t++) begin
         logic [3:0] eLvl, ePrs, eRel, eRpt;
         tick();
         eLvl = (t >= 10 && t < 60) ? 4'h4 : 4'h0;
         ePrs = (t == 10) ? 4'h4 : 4'h0;
         eRel = (t == 60) ? 4'h4 : 4'h0;
         eRpt = (t >= 30 && t <= 55 && (t % 5) == 0) ? 4'h4 : 4'h0;
         checkOutput($sformatf("k2_repeat_t%0d", t), eLvl, ePrs, eRel, eRpt);
         if (t == 50) applyStimulus(1'b1, 4'hF);
      end

      // Key 1 held through a 3-cycle reset is treated as a fresh press afterwards
      applyStimulus(1'b1, 4'hD);
      for (int t = 0; t < 12; t++) tick();
      checkOutput("k1_held", 4'h2, 4'h0, 4'h0, 4'h0);
      applyStimulus(1'b0, 4'hD);
      for (int t = 1; t <= 3; t++) begin
         tick();
         checkOutput($sformatf("k1_inreset_%0d", t), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      applyStimulus(1'b1, 4'hD);
      for (int t = 1; t <= 11; t++) begin
         tick();
         if (t < 10)
            checkOutput($sformatf("k1_postreset_%0d", t), 4'h0, 4'h0, 4'h0, 4'h0);
         else if (t == 10)
            checkOutput("k1_postreset_press", 4'h2, 4'h2, 4'h0, 4'h0);
         else
            checkOutput("k1_postreset_after", 4'h2, 4'h0, 4'h0, 4'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
